// File: rtl/bus_pkg.sv
// Shared constants and helpers for the pipelined bus multiplexer.
// Optional feature macro used by this slice: BUS_MUX_PIPE_PARITY_EN.
package bus_pkg;

   localparam int BUS_WIDTH  = 32;
   localparam int BUS_NUM_IN = 16;
   localparam int BUS_MAX_IN = 64;

   // Lowest set index wins; an all-zero vector returns 0.
   function automatic logic [5:0] onehot_to_index(input logic [BUS_MAX_IN-1:0] vec);
      logic [5:0] idx;
      idx = '0;
      for (int i = BUS_MAX_IN - 1; i >= 0; i--) begin
         if (vec[i]) idx = 6'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Combinational priority encoder for a one-hot select: lowest set index plus
// zero-hot / multi-hot flags. No state.
module onehot_prio_enc
   import bus_pkg::*;
#(
   parameter int NUM_IN = BUS_NUM_IN,
   parameter int SEL_W  = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] vec,
   output logic [SEL_W-1:0]  index,
   output logic              zero,
   output logic              multi
);

   logic [BUS_MAX_IN-1:0] w_vec_ext;
   logic [NUM_IN-1:0]     w_rest;

   assign w_vec_ext = BUS_MAX_IN'(vec);
   assign index     = SEL_W'(onehot_to_index(w_vec_ext));
   assign zero      = ~|vec;

   // Clearing the lowest set bit leaves something only when two or more were set.
   assign w_rest    = vec & (vec - NUM_IN'(1));
   assign multi     = |w_rest;

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered NUM_IN:1 bus multiplexer with one-hot select, valid/ready output
// stage and a saturating illegal-select counter. Optional BUS_MUX_PIPE_PARITY_EN.
module bus_mux_pipe
   import bus_pkg::*;
#(
   parameter int WIDTH     = BUS_WIDTH,
   parameter int NUM_IN    = BUS_NUM_IN,
   parameter int SEL_W     = $clog2(NUM_IN),
   parameter int ERR_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       sel_onehot,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_err,
   output logic [ERR_CNT_W-1:0]    err_count
`ifdef BUS_MUX_PIPE_PARITY_EN
   ,
   output logic                    out_parity
`endif
);

   logic [SEL_W-1:0]     w_index;
   logic                 w_zero;
   logic                 w_multi;
   logic                 w_illegal;
   logic [NUM_IN-1:0]    w_lowest;
   logic [WIDTH-1:0]     w_sel_data;
   logic                 w_accept;
   logic                 w_drain;

   logic [WIDTH-1:0]     r_out_data;
   logic [SEL_W-1:0]     r_out_sel;
   logic                 r_out_valid;
   logic                 r_out_err;
   logic [ERR_CNT_W-1:0] r_err_count;

   onehot_prio_enc #(
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_enc (
      .vec   (sel_onehot),
      .index (w_index),
      .zero  (w_zero),
      .multi (w_multi)
   );

   assign w_illegal = w_zero || w_multi;

   // Isolate the lowest set bit so multi-hot selects pick the same source the
   // encoder reports; zero-hot isolates nothing and yields an all-zero bus.
   always_comb begin
      w_lowest   = sel_onehot & (~sel_onehot + NUM_IN'(1));
      w_sel_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         w_sel_data = w_sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{w_lowest[i]}});
      end
   end

   // Handshake: a beat moves on any edge where valid && ready. The stage holds
   // one beat; it is ready when empty or when its beat drains this same cycle.
   assign in_ready = !r_out_valid || out_ready;
   assign w_accept = in_valid && in_ready;
   assign w_drain  = r_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_accept) begin
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_index;
            r_out_err   <= w_illegal;
            r_out_valid <= 1'b1;
         end else if (w_drain) begin
            r_out_valid <= 1'b0;
         end
         if (w_accept && w_illegal && (r_err_count != {ERR_CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;
   assign out_valid = r_out_valid;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

`ifdef BUS_MUX_PIPE_PARITY_EN
   logic r_out_parity;

   always_ff @(posedge clk) begin
      if (clr) begin
         r_out_parity <= 1'b0;
      end else if (w_accept) begin
         r_out_parity <= ^w_sel_data;
      end
   end

   assign out_parity = r_out_parity;
`endif

endmodule
